// File: rtl/seed_random_pkg.sv
// Shared definitions for the seed_random family of card-dealing blocks:
// dealer FSM state encoding, default LFSR taps/seeds and card rank constants.
package seed_random_pkg;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      SEARCH = 2'd1,
      EMIT   = 2'd2
   } state_e;

   // Maximal-length Galois masks and nonzero seeds for common LFSR widths
   localparam logic [7:0]  TAPS_W8  = 8'hB8;
   localparam logic [7:0]  SEED_W8  = 8'hA5;
   localparam logic [15:0] TAPS_W16 = 16'hB400;
   localparam logic [15:0] SEED_W16 = 16'hACE1;

   localparam int unsigned RANKS_PER_SUIT = 13;

endpackage

// File: rtl/seed_random_lfsr.sv
// Free-running Galois LFSR; shifts right every clock, XORing TAPS when the
// bit shifted out is 1. A nonzero SEED keeps it off the all-zero lock state.
// Ports:
//   clk    - clock, rising edge
//   rst_n  - asynchronous reset, active low (loads SEED)
//   value  - current LFSR state
module seed_random_lfsr #(
   parameter int unsigned      WIDTH = 8,
   parameter logic [WIDTH-1:0] TAPS  = WIDTH'(8'hB8),
   parameter logic [WIDTH-1:0] SEED  = WIDTH'(8'hA5)
) (
   input  logic             clk,
   input  logic             rst_n,
   output logic [WIDTH-1:0] value
);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         value <= SEED;
      end else if (value[0]) begin
         value <= (value >> 1) ^ TAPS;
      end else begin
         value <= value >> 1;
      end
   end

endmodule

// File: rtl/seed_random_4_data_path_dealer.sv
// Card dealer: draws card indices without replacement from a DECK_SIZE deck.
// The starting candidate is taken from a free-running LFSR at the request
// edge; a used-card bitmap is linearly probed (wrapping) to the next free slot.
// Ports:
//   clk_dp_c_i             - clock, rising edge
//   rst_dp_c_i             - asynchronous reset, active low
//   req_card_state_dp_c_i  - request level; each rising edge requests one card
//   shuffle_dp_c_i         - return all cards to the deck (IDLE only)
//   card_o                 - index of the last dealt card
//   card_valid_o           - one-cycle pulse when card_o updates
//   busy_o                 - high while a draw is in progress
//   cards_left_o           - cards remaining in the deck
//   deck_empty_o           - cards_left_o == 0
//   seed_o                 - current LFSR value
//   rank_o                 - (idx mod 13) + 1, only with SEED_RANDOM_4_RANK_OUT_EN
// Optional feature macro: SEED_RANDOM_4_RANK_OUT_EN
module seed_random_4_data_path_dealer
   import seed_random_pkg::*;
#(
   parameter int unsigned      WIDTH     = 8,
   parameter logic [WIDTH-1:0] TAPS      = WIDTH'(TAPS_W8),
   parameter logic [WIDTH-1:0] SEED      = WIDTH'(SEED_W8),
   parameter int unsigned      DECK_SIZE = 52,
   parameter int unsigned      IDX_W     = 6
) (
   input  logic               clk_dp_c_i,
   input  logic               rst_dp_c_i,
   input  logic               req_card_state_dp_c_i,
   input  logic               shuffle_dp_c_i,
   output logic [IDX_W-1:0]   card_o,
   output logic               card_valid_o,
   output logic               busy_o,
   output logic [IDX_W:0]     cards_left_o,
   output logic               deck_empty_o,
   output logic [WIDTH-1:0]   seed_o
`ifdef SEED_RANDOM_4_RANK_OUT_EN
   ,
   output logic [3:0]         rank_o
`endif
);

   localparam logic [IDX_W:0]   DECK_CNT = (IDX_W+1)'(DECK_SIZE);
   localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(DECK_SIZE - 1);

   state_e                 state_q;
   state_e                 state_d;
   logic                   req_q;
   logic [DECK_SIZE-1:0]   used_q;
   logic [IDX_W-1:0]       idx_q;
   logic [IDX_W:0]         cards_left_q;
   logic [IDX_W-1:0]       cand;
   logic [IDX_W-1:0]       cand_fold;
   logic                   req_rise;
   logic                   shuffle_go;
   logic                   start_draw;
   logic                   hit;

   seed_random_lfsr #(
      .WIDTH (WIDTH),
      .TAPS  (TAPS),
      .SEED  (SEED)
   ) u_lfsr (
      .clk   (clk_dp_c_i),
      .rst_n (rst_dp_c_i),
      .value (seed_o)
   );

   // Single conditional subtract maps the raw LFSR slice into 0..DECK_SIZE-1
   assign cand      = seed_o[IDX_W-1:0];
   assign cand_fold = ({1'b0, cand} >= DECK_CNT) ? cand - IDX_W'(DECK_SIZE) : cand;
   assign req_rise  = req_card_state_dp_c_i & ~req_q;

   // State register
   always_ff @(posedge clk_dp_c_i or negedge rst_dp_c_i) begin
      if (!rst_dp_c_i) begin
         state_q <= IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   // Next-state logic; shuffle has priority over a coincident request
   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE: begin
            if (!shuffle_dp_c_i && req_rise && (cards_left_q != '0)) begin
               state_d = SEARCH;
            end
         end
         SEARCH: begin
            if (!used_q[idx_q]) begin
               state_d = EMIT;
            end
         end
         EMIT:    state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   // Control strobes and status decoded from the current state
   always_comb begin
      shuffle_go   = (state_q == IDLE) && shuffle_dp_c_i;
      start_draw   = (state_q == IDLE) && !shuffle_dp_c_i && req_rise && (cards_left_q != '0);
      hit          = (state_q == SEARCH) && !used_q[idx_q];
      busy_o       = (state_q != IDLE);
      deck_empty_o = (cards_left_q == '0);
   end

   assign cards_left_o = cards_left_q;

   // Datapath: request edge register, bitmap, probe index, dealt card
   always_ff @(posedge clk_dp_c_i or negedge rst_dp_c_i) begin
      if (!rst_dp_c_i) begin
         req_q        <= 1'b0;
         used_q       <= '0;
         idx_q        <= '0;
         cards_left_q <= DECK_CNT;
         card_o       <= '0;
         card_valid_o <= 1'b0;
`ifdef SEED_RANDOM_4_RANK_OUT_EN
         rank_o       <= 4'd0;
`endif
      end else begin
         req_q        <= req_card_state_dp_c_i;
         card_valid_o <= hit;
         if (shuffle_go) begin
            used_q       <= '0;
            cards_left_q <= DECK_CNT;
         end
         if (start_draw) begin
            idx_q <= cand_fold;
         end
         if (hit) begin
            used_q[idx_q] <= 1'b1;
            card_o        <= idx_q;
            cards_left_q  <= cards_left_q - (IDX_W+1)'(1);
`ifdef SEED_RANDOM_4_RANK_OUT_EN
            rank_o        <= 4'((32'(idx_q) % RANKS_PER_SUIT) + 32'd1);
`endif
         end else if (state_q == SEARCH) begin
            idx_q <= (idx_q == LAST_IDX) ? '0 : idx_q + IDX_W'(1);
         end
      end
   end

endmodule

// File: tb/tb_seed_random_4_data_path_dealer.sv
// Scoreboard bench for the card dealer with a 4-card deck and 8-bit LFSR.
module tb_seed_random_4_data_path_dealer;

   logic       clk;
   logic       rst_n;
   logic       req;
   logic       shuffle;
   logic [1:0] card_o;
   logic       card_valid_o;
   logic       busy_o;
   logic [2:0] cards_left_o;
   logic       deck_empty_o;
   logic [7:0] seed_o;

   seed_random_4_data_path_dealer #(
      .WIDTH     (8),
      .TAPS      (8'hB8),
      .SEED      (8'hA5),
      .DECK_SIZE (4),
      .IDX_W     (2)
   ) dut (
      .clk_dp_c_i            (clk),
      .rst_dp_c_i            (rst_n),
      .req_card_state_dp_c_i (req),
      .shuffle_dp_c_i        (shuffle),
      .card_o                (card_o),
      .card_valid_o          (card_valid_o),
      .busy_o                (busy_o),
      .cards_left_o          (cards_left_o),
      .deck_empty_o          (deck_empty_o),
      .seed_o                (seed_o)
   );

   typedef struct {
      logic [1:0] card;
      logic [2:0] left;
   } exp_t;

   exp_t q[$];
   int   n_pass  = 0;
   int   n_total = 0;
   bit   used[4];
   int   left;
   logic [7:0] m_lfsr;

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Reference LFSR: lfsr[0] ? (lfsr >> 1) ^ B8 : lfsr >> 1
   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) m_lfsr <= 8'hA5;
      else        m_lfsr <= m_lfsr[0] ? ((m_lfsr >> 1) ^ 8'hB8) : (m_lfsr >> 1);
   end

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_total++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %0h expected %0h", name, act, exp);
   endtask

   // Monitor: LFSR every cycle, dealt cards against the scoreboard queue
   always @(negedge clk) begin
      if (rst_n) begin
         check("seed", 32'(seed_o), 32'(m_lfsr));
         if (card_valid_o) begin
            if (q.size() == 0) begin
               check("valid_unexpected", 32'(card_valid_o), 32'd0);
            end else begin
               exp_t e;
               e = q.pop_front();
               check("card", 32'(card_o), 32'(e.card));
               check("cards_left", 32'(cards_left_o), 32'(e.left));
               check("deck_empty", 32'(deck_empty_o), 32'(e.left == 3'd0));
            end
         end
      end
   end

   // Issue one request (held for 'hold' cycles); predict card and latency
   task automatic deal(input int hold);
      logic [1:0] idx;
      int         k;
      int         lat;
      bit         done;
      @(negedge clk);
      req = 1'b1;
      idx = m_lfsr[1:0];
      k   = 0;
      while (used[idx]) begin
         idx = (idx == 2'd3) ? 2'd0 : idx + 2'd1;
         k++;
      end
      used[idx] = 1'b1;
      left--;
      q.push_back('{idx, 3'(left)});
      lat  = 0;
      done = 1'b0;
      for (int c = 1; c <= 20 && !done; c++) begin
         @(negedge clk);
         if (c >= hold) req = 1'b0;
         if (card_valid_o && lat == 0) lat = c;
         if (lat != 0 && c >= hold && !busy_o) done = 1'b1;
      end
      req = 1'b0;
      check("latency", 32'(lat), 32'(2 + k));
      check("busy_released", 32'(done), 32'd1);
   endtask

   task automatic clear_model();
      for (int i = 0; i < 4; i++) used[i] = 1'b0;
      left = 4;
   endtask

   initial begin
      rst_n   = 1'b0;
      req     = 1'b0;
      shuffle = 1'b0;
      clear_model();
      repeat (3) @(negedge clk);
      check("rst_card", 32'(card_o), 32'd0);
      check("rst_valid", 32'(card_valid_o), 32'd0);
      check("rst_busy", 32'(busy_o), 32'd0);
      check("rst_left", 32'(cards_left_o), 32'd4);
      check("rst_empty", 32'(deck_empty_o), 32'd0);
      check("rst_seed", 32'(seed_o), 32'hA5);

      // LFSR sequence after release
      rst_n = 1'b1;
      #1 check("lfsr0", 32'(seed_o), 32'hA5);
      @(negedge clk); check("lfsr1", 32'(seed_o), 32'hEA);
      @(negedge clk); check("lfsr2", 32'(seed_o), 32'h75);
      @(negedge clk); check("lfsr3", 32'(seed_o), 32'h82);

      // Full deal of the 4-card deck
      for (int i = 0; i < 4; i++) deal(1);
      check("full_empty", 32'(deck_empty_o), 32'd1);
      check("full_left", 32'(cards_left_o), 32'd0);

      // Request while empty is ignored
      @(negedge clk); req = 1'b1;
      for (int c = 0; c < 4; c++) begin
         @(negedge clk); req = 1'b0;
         check("empty_busy", 32'(busy_o), 32'd0);
      end
      check("empty_left", 32'(cards_left_o), 32'd0);

      // Shuffle restores the deck
      @(negedge clk); shuffle = 1'b1;
      @(negedge clk); shuffle = 1'b0;
      clear_model();
      check("shuf_left", 32'(cards_left_o), 32'd4);
      check("shuf_empty", 32'(deck_empty_o), 32'd0);

      // Shuffle wins over a coincident request edge
      deal(1);
      @(negedge clk); shuffle = 1'b1; req = 1'b1;
      @(negedge clk); shuffle = 1'b0;
      clear_model();
      for (int c = 0; c < 4; c++) begin
         @(negedge clk);
         check("shufreq_busy", 32'(busy_o), 32'd0);
      end
      req = 1'b0;
      check("shufreq_left", 32'(cards_left_o), 32'd4);

      // Held request yields one card; then drain with varied gaps
      deal(5);
      for (int g = 0; g < 3; g++) begin
         repeat (g) @(negedge clk);
         deal(1);
      end
      check("drain_empty", 32'(deck_empty_o), 32'd1);
      @(negedge clk); shuffle = 1'b1;
      @(negedge clk); shuffle = 1'b0;
      clear_model();

      // Reset while searching aborts the draw
      @(negedge clk); req = 1'b1;
      @(negedge clk); req = 1'b0;
      check("mid_busy", 32'(busy_o), 32'd1);
      #2 rst_n = 1'b0;
      #1;
      check("mid_card", 32'(card_o), 32'd0);
      check("mid_valid", 32'(card_valid_o), 32'd0);
      check("mid_busy_rst", 32'(busy_o), 32'd0);
      check("mid_left", 32'(cards_left_o), 32'd4);
      check("mid_empty", 32'(deck_empty_o), 32'd0);
      check("mid_seed", 32'(seed_o), 32'hA5);
      @(negedge clk); rst_n = 1'b1;
      clear_model();
      repeat (6) @(negedge clk);
      check("post_rst_busy", 32'(busy_o), 32'd0);
      deal(1);
      deal(1);

      repeat (4) @(negedge clk);
      check("pending", 32'(q.size()), 32'd0);
      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
